// File: rtl/store_narrow_32_16.sv
// Store-path width reducer: one 32-bit store becomes one or two
// 16-bit little-endian beats, with byte enables and misalign detection.
module store_narrow_32_16 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic [1:0]        out_be,
  output logic              out_last,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [15:0]       r_data;
  logic [15:0]       w_data_nx;
  logic [15:0]       r_hi;
  logic [15:0]       w_hi_nx;
  logic [1:0]        r_be;
  logic [1:0]        w_be_nx;
  logic              r_last;
  logic              w_last_nx;
  logic              r_err;
  logic              w_err_nx;

  logic w_word;
  logic w_half;
  logic w_byte;

  assign w_word = (in_size == 2'b10) && (in_addr[1:0] == 2'b00);
  assign w_half = (in_size == 2'b01) && !in_addr[0];
  assign w_byte = (in_size == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_hi    <= '0;
      r_be    <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_hi    <= w_hi_nx;
      r_be    <= w_be_nx;
      r_last  <= w_last_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_hi_nx    = r_hi;
    w_be_nx    = r_be;
    w_last_nx  = r_last;
    w_err_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            w_word: begin
              w_state_nx = BEAT0;
              w_addr_nx  = in_addr;
              w_data_nx  = in_data[15:0];
              w_hi_nx    = in_data[31:16];
              w_be_nx    = 2'b11;
              w_last_nx  = 1'b0;
            end
            w_half: begin
              w_state_nx = BEAT0;
              w_addr_nx  = in_addr;
              w_data_nx  = in_data[15:0];
              w_be_nx    = 2'b11;
              w_last_nx  = 1'b1;
            end
            w_byte: begin
              w_state_nx = BEAT0;
              w_addr_nx  = {in_addr[ADDR_W-1:1], 1'b0};
              w_data_nx  = {in_data[7:0], in_data[7:0]};
              w_be_nx    = in_addr[0] ? 2'b10 : 2'b01;
              w_last_nx  = 1'b1;
            end
            default: w_err_nx = 1'b1;
          endcase
        end
      end
      BEAT0: begin
        if (out_ready) begin
          if (r_last) begin
            w_state_nx = IDLE;
          end else begin
            // wraps modulo 2^ADDR_W by construction
            w_state_nx = BEAT1;
            w_addr_nx  = r_addr + ADDR_W'(2);
            w_data_nx  = r_hi;
            w_be_nx    = 2'b11;
            w_last_nx  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state != IDLE);
  assign out_addr     = r_addr;
  assign out_data     = r_data;
  assign out_be       = r_be;
  assign out_last     = r_last;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_store_narrow_32_16.sv
// Scoreboard bench for store_narrow_32_16: expected beats are queued
// when a store is driven and popped when the DUT hands a beat over.
module tb_store_narrow_32_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [15:0] out_data;
  logic [1:0]  out_be;
  logic        out_last;
  logic        misalign_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic        last;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  store_narrow_32_16 #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_size      (in_size),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_be       (out_be),
    .out_last     (out_last),
    .misalign_err (misalign_err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (misalign_err && out_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL err_with_beat: misalign_err=1 out_valid=1, want not both");
      end
      if (out_valid && out_ready) begin
        beat_t got;
        beat_t exp;
        vectors++;
        got = '{a: out_addr, d: out_data, be: out_be, last: out_last};
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got %h, want no beat", got);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL beat: got a=%h d=%h be=%b last=%b, want a=%h d=%h be=%b last=%b",
                     got.a, got.d, got.be, got.last, exp.a, exp.d, exp.be, exp.last);
          end
        end
      end
    end
  end

  // Drives one request, queues the beats the spec predicts, returns
  // at posedge+1 after the accept edge with the number of cycles waited.
  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, output int waits);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    case (s)
      2'b10: if (a[1:0] == 2'b00) begin
        q.push_back('{a: a, d: d[15:0], be: 2'b11, last: 1'b0});
        q.push_back('{a: a + 32'd2, d: d[31:16], be: 2'b11, last: 1'b1});
      end
      2'b01: if (!a[0])
        q.push_back('{a: a, d: d[15:0], be: 2'b11, last: 1'b1});
      2'b00:
        q.push_back('{a: {a[31:1], 1'b0}, d: {d[7:0], d[7:0]},
                      be: a[0] ? 2'b10 : 2'b01, last: 1'b1});
      default: ;
    endcase
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_data  = $urandom;
    in_size  = 2'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending=%0d, want 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_size = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_addr, out_data, out_be, out_last, misalign_err}
        !== {1'b1, 1'b0, 32'd0, 16'd0, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b v=%b a=%h d=%h be=%b l=%b e=%b, want 1 0 0 0 00 0 0",
               in_ready, out_valid, out_addr, out_data, out_be, out_last, misalign_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_word();
    int w;
    logic [2:0] rdy;
    out_ready = 1'b1;
    send(32'h100, 32'hDEADBEEF, 2'b10, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rdy[i] = in_ready;
    end
    vectors++;
    if (rdy !== 3'b100) begin
      miscompares++;
      $display("FAIL word_in_ready: got %b, want 100", rdy);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_half_byte();
    int w;
    send(32'h206, 32'h00001234, 2'b01, w);
    wait_drain();
    send(32'h301, 32'h000000AB, 2'b00, w);
    wait_drain();
    send(32'h300, 32'h000000AB, 2'b00, w);
    wait_drain();
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    int w;
    addrs = '{32'h102, 32'h203, 32'h400};
    sizes = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      send(addrs[i], 32'hCAFEF00D, sizes[i], w);
      @(negedge clk);
      vectors++;
      if ({misalign_err, out_valid, in_ready} !== 3'b101) begin
        miscompares++;
        $display("FAIL misalign_pulse[%0d]: err/v/rdy=%b, want 101", i,
                 {misalign_err, out_valid, in_ready});
      end
      @(negedge clk);
      vectors++;
      if ({misalign_err, out_valid, in_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL misalign_after[%0d]: err/v/rdy=%b, want 001", i,
                 {misalign_err, out_valid, in_ready});
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b0;
    send(32'h400, 32'h12345678, 2'b10, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_addr, out_data, out_be, out_last}
          !== {1'b1, 32'h400, 16'h5678, 2'b11, 1'b0}) begin
        miscompares++;
        $display("FAIL hold[%0d]: v=%b a=%h d=%h be=%b l=%b, want 1 400 5678 11 0",
                 i, out_valid, out_addr, out_data, out_be, out_last);
      end
      @(posedge clk);
      #1;
      if (i == 2) out_ready = 1'b1;
    end
    send(32'h500, 32'h0000A5A5, 2'b01, w);
    vectors++;
    if (w !== 2) begin
      miscompares++;
      $display("FAIL b2b_wait: got %0d cycles, want 2", w);
    end
    wait_drain();
  endtask

  task automatic test_reset_beat1();
    int w;
    out_ready = 1'b1;
    send(32'h600, 32'h11223344, 2'b10, w);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready, out_addr, out_be} !== {1'b0, 1'b1, 32'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL rst_beat1: v=%b rdy=%b a=%h be=%b, want 0 1 0 00",
               out_valid, in_ready, out_addr, out_be);
    end
    vectors++;
    if (q.size() !== 1) begin
      miscompares++;
      $display("FAIL rst_discard: pending=%0d, want 1", q.size());
    end
    q.delete();
    @(posedge clk);
    #1;
    send(32'hFFFFFFFC, 32'h9876FEDC, 2'b10, w);
    wait_drain();
  endtask

  task automatic test_random();
    int w;
    logic [1:0]  s;
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      s = 2'($urandom_range(0, 2));
      a = $urandom;
      if (s == 2'b10) a[1:0] = 2'b00;
      if (s == 2'b01) a[0] = 1'b0;
      out_ready = 1'($urandom);
      send(a, $urandom, s, w);
      for (int k = 0; k < 6; k++) begin
        out_ready = 1'($urandom);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      wait_drain();
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_half_byte();
    test_misalign();
    test_back_to_back();
    test_reset_beat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
